// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer
//
// Fetch-stage PC and IF/ID register owner. It takes the hazard unit's
// pcSrc/bubbleSignal decisions and uses them to stall, redirect or advance
// the PC. It also assembles two-word instructions, where the second word is
// the immediate, before they are handed to decode.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, this adds the saturating 16-bit counters stallCount,
//   redirectCount and flushCount, which all clear on rst.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   pcSrc               00 sequential, 01 load branchTarget, 10 stay, 11 = 00
//   bubbleSignal        stall fetch
//   branchTarget        redirect address
//   branchConditional   1 = conditional branch (also kills ID/EX), 0 = JMP
//   instrIn             instruction-memory word at instrAddr
//   instrIsTwoWord      predecode: next word is the immediate of instrIn
//   instrAddr           current PC (combinational from the PC register)
//   ifidInstr/Imm/Pc    IF/ID payload handed to decode
//   ifidValid           IF/ID holds a real instruction
//   flushIdEx           one-cycle pulse that kills the ID/EX instruction
module fetch_pc_sequencer #(
  parameter int                      PC_WIDTH     = 32,
  parameter int                      INSTR_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP_WORD     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             pcSrc,
  input  logic                   bubbleSignal,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  input  logic                   branchConditional,
  input  logic [INSTR_WIDTH-1:0] instrIn,
  input  logic                   instrIsTwoWord,
  output logic [PC_WIDTH-1:0]    instrAddr,
  output logic [INSTR_WIDTH-1:0] ifidInstr,
  output logic [INSTR_WIDTH-1:0] ifidImm,
  output logic [PC_WIDTH-1:0]    ifidPc,
  output logic                   ifidValid,
  output logic                   flushIdEx
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]            stallCount,
  output logic [15:0]            redirectCount,
  output logic [15:0]            flushCount
`endif
);

  typedef enum logic {RUN = 1'b0, FETCH_IMM = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [INSTR_WIDTH-1:0] ifid_imm_q, ifid_imm_d;
  logic [PC_WIDTH-1:0]    ifid_pc_q, ifid_pc_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic                   flush_q, flush_d;
  logic [INSTR_WIDTH-1:0] held_word_q, held_word_d;
  logic [PC_WIDTH-1:0]    held_pc_q, held_pc_d;

  logic stall;
  logic redirect;
  logic [PC_WIDTH-1:0] pc_inc;

  // A stall outranks a redirect. A redirect that arrives during a bubble is
  // therefore dropped here; the hazard unit re-presents it afterwards.
  assign stall    = bubbleSignal || (pcSrc == 2'b10);
  assign redirect = (pcSrc == 2'b01);
  // The PC wraps silently.
  assign pc_inc   = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_imm_d   = ifid_imm_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    held_word_d  = held_word_q;
    held_pc_d    = held_pc_q;
    flush_d      = 1'b0;

    if (stall) begin
      // Everything holds, including a half-assembled instruction.
    end else if (redirect) begin
      pc_d         = branchTarget;
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
      state_d      = RUN;
      flush_d      = branchConditional;
    end else begin
      pc_d = pc_inc;
      case (state_q)
        RUN: begin
          if (instrIsTwoWord) begin
            held_word_d  = instrIn;
            held_pc_d    = pc_q;
            ifid_valid_d = 1'b0;
            state_d      = FETCH_IMM;
          end else begin
            ifid_instr_d = instrIn;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
          end
        end
        FETCH_IMM: begin
          // The current word is the immediate. Its predecode bit is meaningless.
          ifid_instr_d = held_word_q;
          ifid_imm_d   = instrIn;
          ifid_pc_d    = held_pc_q;
          ifid_valid_d = 1'b1;
          state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      ifid_instr_q <= NOP_WORD;
      ifid_imm_q   <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      held_word_q  <= '0;
      held_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_imm_q   <= ifid_imm_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      flush_q      <= flush_d;
      held_word_q  <= held_word_d;
      held_pc_q    <= held_pc_d;
    end
  end

  assign instrAddr = pc_q;
  assign ifidInstr = ifid_instr_q;
  assign ifidImm   = ifid_imm_q;
  assign ifidPc    = ifid_pc_q;
  assign ifidValid = ifid_valid_q;
  assign flushIdEx = flush_q;

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] redir_cnt_q, redir_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall)               stall_cnt_d = sat_inc(stall_cnt_q);
    if (!stall && redirect)  redir_cnt_d = sat_inc(redir_cnt_q);
    // Counted as each pulse is issued; every pulse lasts exactly one cycle.
    if (flush_d)             flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount    = stall_cnt_q;
  assign redirectCount = redir_cnt_q;
  assign flushCount    = flush_cnt_q;
`endif

endmodule
